// File: rtl/serial_descrambler_framer.sv
// Descrambles an x^7+x^6+1 self-synchronizing serial stream and acquires frame alignment
// on a periodic sync word, forwarding only payload bits of locked frames.
`timescale 1ns/1ps

// state     | meaning
// ST_HUNT   | searching every bit for the sync word
// ST_VERIFY | candidate alignment found, confirming at frame boundaries
// ST_LOCK   | aligned, payload forwarded, tolerating up to LOSS_CNT-1 misses
module serial_descrambler_framer #(
    parameter int unsigned         SYNC_LEN    = 16,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 16'hF628,
    parameter int unsigned         FRAME_LEN   = 256,
    parameter int unsigned         CONFIRM_CNT = 2,
    parameter int unsigned         LOSS_CNT    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_scramble_data,
    output logic       out_data,
    output logic       out_valid,
    output logic       frame_start,
    output logic       lock,
    output logic [1:0] sync_state
);

    localparam int unsigned WARM_MAX = 7 + SYNC_LEN;
    localparam int unsigned WARM_W   = $clog2(WARM_MAX + 1);
    localparam int unsigned CNT_W    = $clog2(FRAME_LEN + 1);
    localparam int unsigned CONF_W   = $clog2(CONFIRM_CNT + 1);
    localparam int unsigned MISS_W   = $clog2(LOSS_CNT + 1);

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_MAX);
    localparam logic [CNT_W-1:0]  FRAME_END = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  PAY_END   = CNT_W'(FRAME_LEN - SYNC_LEN);
    localparam logic [CONF_W-1:0] CONF_TGT  = CONF_W'(CONFIRM_CNT);
    localparam logic [MISS_W-1:0] MISS_TGT  = MISS_W'(LOSS_CNT);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          sr_q, sr_d;
    // The oldest window bit is only ever needed inside the compare, so it is not stored.
    logic [SYNC_LEN-2:0] win_q, win_d;
    logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CONF_W-1:0]   confirm_q, confirm_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_start_q, frame_start_d;
    logic                lock_q, lock_d;

    logic                descr;
    logic [SYNC_LEN-1:0] win_nxt;
    logic [WARM_W-1:0]   warm_inc;
    logic                warm;
    logic                match;
    logic [CNT_W-1:0]    nxt;
    logic                boundary;
    logic                payload;
    logic [CONF_W-1:0]   confirm_inc;
    logic [MISS_W-1:0]   miss_inc;

    always_comb begin
        descr       = in_scramble_data ^ sr_q[6] ^ sr_q[5];
        win_nxt     = {win_q, descr};
        warm_inc    = (warm_cnt_q == WARM_LAST) ? WARM_LAST : warm_cnt_q + WARM_W'(1);
        warm        = (warm_inc == WARM_LAST);
        match       = warm && (win_nxt == SYNC_WORD);
        nxt         = bit_cnt_q + CNT_W'(1);
        boundary    = (nxt == FRAME_END);
        payload     = (state_q == ST_LOCK) && (nxt != '0) && (nxt <= PAY_END);
        confirm_inc = confirm_q + CONF_W'(1);
        miss_inc    = miss_q + MISS_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        win_d         = win_q;
        warm_cnt_d    = warm_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        confirm_d     = confirm_q;
        miss_d        = miss_q;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;

        if (in_valid) begin
            sr_d       = {sr_q[5:0], in_scramble_data};
            win_d      = win_nxt[SYNC_LEN-2:0];
            warm_cnt_d = warm_inc;

            if (payload) begin
                out_data_d    = descr;
                out_valid_d   = 1'b1;
                frame_start_d = (nxt == CNT_W'(1));
            end

            case (state_q)
                ST_HUNT: begin
                    bit_cnt_d = '0;
                    if (match) begin
                        confirm_d = CONF_W'(1);
                        state_d   = (CONFIRM_CNT == 1) ? ST_LOCK : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (boundary) begin
                        bit_cnt_d = '0;
                        if (match) begin
                            confirm_d = confirm_inc;
                            if (confirm_inc == CONF_TGT) begin
                                state_d = ST_LOCK;
                            end
                        end else begin
                            confirm_d = '0;
                            state_d   = ST_HUNT;
                        end
                    end else begin
                        bit_cnt_d = nxt;
                    end
                end
                ST_LOCK: begin
                    // A missed sync still restarts the frame; alignment is kept until loss.
                    if (boundary) begin
                        bit_cnt_d = '0;
                        if (match) begin
                            miss_d = '0;
                        end else if (miss_inc == MISS_TGT) begin
                            miss_d    = '0;
                            confirm_d = '0;
                            state_d   = ST_HUNT;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else begin
                        bit_cnt_d = nxt;
                    end
                end
                default: begin
                    bit_cnt_d = '0;
                    state_d   = ST_HUNT;
                end
            endcase
        end

        lock_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_HUNT;
            sr_q          <= 7'h7F;
            win_q         <= '0;
            warm_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            confirm_q     <= '0;
            miss_q        <= '0;
            out_data_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            lock_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            win_q         <= win_d;
            warm_cnt_q    <= warm_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            confirm_q     <= confirm_d;
            miss_q        <= miss_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            lock_q        <= lock_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign lock        = lock_q;
    assign sync_state  = state_q;

endmodule

// File: tb/tb_serial_descrambler_framer.sv
// Randomized bench for serial_descrambler_framer: scrambled framed streams checked against a
// bit-history reference model and against the original payload source.
`timescale 1ns/1ps

module tb_serial_descrambler_framer;

    localparam int SL    = 16;
    localparam int FL    = 256;
    localparam int PL    = FL - SL;
    localparam int CONF  = 2;
    localparam int LOSS  = 3;
    localparam logic [15:0] SW = 16'hF628;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_scramble_data;
    logic       out_data;
    logic       out_valid;
    logic       frame_start;
    logic       lock;
    logic [1:0] sync_state;

    int checks;
    int errors;

    serial_descrambler_framer #(
        .SYNC_LEN(SL), .SYNC_WORD(SW), .FRAME_LEN(FL), .CONFIRM_CNT(CONF), .LOSS_CNT(LOSS)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_scramble_data(in_scramble_data),
        .out_data(out_data), .out_valid(out_valid), .frame_start(frame_start),
        .lock(lock), .sync_state(sync_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full history of accepted bits, frame position and counters as integers.
    bit sq[$];
    bit dq[$];
    int m_state;
    int m_pos;
    int m_conf;
    int m_miss;
    bit e_ov, e_fs, e_od;

    // Observation of the DUT
    bit got_q[$];
    int fs_cnt;
    int n_acc;
    int dut_lock_at;

    // Stimulus
    bit tx[$];
    bit pay_src[$];

    function automatic void model_reset();
        sq.delete(); dq.delete();
        m_state = 0; m_pos = 0; m_conf = 0; m_miss = 0;
        e_ov = 0; e_fs = 0; e_od = 0;
        got_q.delete(); fs_cnt = 0; n_acc = 0; dut_lock_at = -1;
    endfunction

    task automatic model_accept(input bit b);
        int n;
        int nxt;
        bit s6, s7, d, m, pay;
        logic [15:0] win;
        n  = sq.size() + 1;
        s6 = (n - 6 >= 1) ? sq[n-7] : 1'b1;
        s7 = (n - 7 >= 1) ? sq[n-8] : 1'b1;
        d  = b ^ s6 ^ s7;
        sq.push_back(b);
        dq.push_back(d);
        m = 1'b0;
        if (n >= SL + 7) begin
            for (int i = 0; i < SL; i++) win[SL-1-i] = dq[n-SL+i];
            m = (win == SW);
        end
        nxt  = m_pos + 1;
        pay  = (m_state == 2) && (nxt >= 1) && (nxt <= PL);
        e_ov = pay;
        e_fs = pay && (nxt == 1);
        if (pay) e_od = d;
        if (m_state == 0) begin
            m_pos = 0;
            if (m) begin
                m_conf  = 1;
                m_state = (CONF == 1) ? 2 : 1;
            end
        end else if (nxt == FL) begin
            m_pos = 0;
            if (m_state == 1) begin
                if (m) begin
                    m_conf++;
                    if (m_conf >= CONF) m_state = 2;
                end else begin
                    m_state = 0; m_conf = 0;
                end
            end else if (m) begin
                m_miss = 0;
            end else begin
                m_miss++;
                if (m_miss >= LOSS) begin
                    m_state = 0; m_miss = 0; m_conf = 0;
                end
            end
        end else begin
            m_pos = nxt;
        end
    endtask

    task automatic drive(input bit v, input bit b);
        in_valid = v;
        in_scramble_data = b;
        @(posedge clk);
        #1;
        if (v) begin
            n_acc++;
            model_accept(b);
        end else begin
            e_ov = 0;
            e_fs = 0;
        end
        if (out_valid === 1'b1) begin
            got_q.push_back(out_data);
            if (frame_start === 1'b1) fs_cnt++;
        end
        if (lock === 1'b1 && dut_lock_at < 0) dut_lock_at = n_acc;
    endtask

    // Payload is kept free of three consecutive zeros so it cannot imitate the sync word.
    task automatic build_stream(input int nfr, input logic [31:0] cmask, input int skip);
        logic [6:0] ssr;
        int cnt;
        int zrun;
        bit p, s;
        ssr = 7'h7F;
        cnt = 0;
        tx.delete();
        pay_src.delete();
        for (int f = 0; f < nfr; f++) begin
            zrun = 0;
            for (int i = 0; i < FL; i++) begin
                if (i < SL) begin
                    p = SW[SL-1-i];
                    if (i == 0 && cmask[f]) p = ~p;
                end else begin
                    p = 1'($urandom_range(0, 1));
                    if (zrun >= 2) p = 1'b1;
                    zrun = p ? 0 : zrun + 1;
                    pay_src.push_back(p);
                end
                s   = p ^ ssr[6] ^ ssr[5];
                ssr = {ssr[5:0], s};
                if (cnt >= skip) tx.push_back(s);
                cnt++;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        in_scramble_data = 1'b0;
        #3;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        in_scramble_data = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got v=%b fs=%b exp 0 0", out_valid, frame_start);
        end
        checks++;
        if (lock !== 1'b0 || sync_state !== 2'd0) begin
            errors++; $display("FAIL reset_state got lock=%b st=%0d exp 0 0", lock, sync_state);
        end
        checks++;
        if (out_data !== 1'b0) begin
            errors++; $display("FAIL reset_data got %b exp 0", out_data);
        end
        in_valid = 1'b1;
        in_scramble_data = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sync_state !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hold got st=%0d v=%b exp 0 0", sync_state, out_valid);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_acquire();
        do_reset();
        build_stream(6, 32'h0, 0);
        for (int i = 0; i < tx.size(); i++) begin
            drive(1'b1, tx[i]);
            checks++;
            if (out_valid !== e_ov || frame_start !== e_fs || sync_state !== m_state[1:0] ||
                lock !== (m_state == 2) || out_data !== e_od) begin
                errors++;
                $display("FAIL acq_cycle bit=%0d got v=%b fs=%b st=%0d lk=%b d=%b exp v=%b fs=%b st=%0d d=%b",
                         i + 1, out_valid, frame_start, sync_state, lock, out_data, e_ov, e_fs, m_state, e_od);
            end
            if (i + 1 == FL + SL) begin
                checks++;
                if (sync_state !== 2'd1) begin
                    errors++; $display("FAIL acq_verify got st=%0d exp 1", sync_state);
                end
            end
        end
        checks++;
        if (dut_lock_at != 2 * FL + SL) begin
            errors++; $display("FAIL acq_lock_at got %0d exp %0d", dut_lock_at, 2 * FL + SL);
        end
        checks++;
        if (got_q.size() != 4 * PL || fs_cnt != 4) begin
            errors++; $display("FAIL acq_count got bits=%0d fs=%0d exp %0d 4", got_q.size(), fs_cnt, 4 * PL);
        end else begin
            int bad = 0;
            for (int i = 0; i < 4 * PL; i++) if (got_q[i] !== pay_src[2 * PL + i]) bad++;
            if (bad != 0) begin
                errors++; $display("FAIL acq_payload got %0d wrong bits exp 0", bad);
            end
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        build_stream(6, 32'h0, 5);
        for (int i = 0; i < tx.size(); i++) begin
            drive(1'b1, tx[i]);
            checks++;
            if (out_valid !== e_ov || frame_start !== e_fs || sync_state !== m_state[1:0] ||
                lock !== (m_state == 2) || out_data !== e_od) begin
                errors++;
                $display("FAIL mis_cycle bit=%0d got v=%b fs=%b st=%0d d=%b exp v=%b fs=%b st=%0d d=%b",
                         i + 1, out_valid, frame_start, sync_state, out_data, e_ov, e_fs, m_state, e_od);
            end
        end
        checks++;
        if (dut_lock_at != 2 * FL + SL - 5) begin
            errors++; $display("FAIL mis_lock_at got %0d exp %0d", dut_lock_at, 2 * FL + SL - 5);
        end
        checks++;
        if (got_q.size() != 4 * PL || fs_cnt != 4) begin
            errors++; $display("FAIL mis_count got bits=%0d fs=%0d exp %0d 4", got_q.size(), fs_cnt, 4 * PL);
        end else begin
            int bad = 0;
            for (int i = 0; i < 4 * PL; i++) if (got_q[i] !== pay_src[2 * PL + i]) bad++;
            if (bad != 0) begin
                errors++; $display("FAIL mis_payload got %0d wrong bits exp 0", bad);
            end
        end
    endtask

    task automatic test_loss();
        do_reset();
        build_stream(12, 32'h0000_0730, 0);
        for (int i = 0; i < tx.size(); i++) begin
            drive(1'b1, tx[i]);
            checks++;
            if (out_valid !== e_ov || frame_start !== e_fs || sync_state !== m_state[1:0] ||
                lock !== (m_state == 2) || out_data !== e_od) begin
                errors++;
                $display("FAIL loss_cycle bit=%0d got v=%b fs=%b st=%0d d=%b exp v=%b fs=%b st=%0d d=%b",
                         i + 1, out_valid, frame_start, sync_state, out_data, e_ov, e_fs, m_state, e_od);
            end
            if (i + 1 == 6 * FL + SL) begin
                checks++;
                if (lock !== 1'b1) begin
                    errors++; $display("FAIL loss_tolerate got lock=%b exp 1", lock);
                end
            end
            if (i + 1 == 10 * FL + SL) begin
                checks++;
                if (sync_state !== 2'd0 || lock !== 1'b0) begin
                    errors++; $display("FAIL loss_drop got st=%0d lock=%b exp 0 0", sync_state, lock);
                end
            end
        end
        checks++;
        if (got_q.size() != 8 * PL || fs_cnt != 8) begin
            errors++; $display("FAIL loss_count got bits=%0d fs=%0d exp %0d 8", got_q.size(), fs_cnt, 8 * PL);
        end else begin
            int bad = 0;
            for (int i = 0; i < 8 * PL; i++) if (got_q[i] !== pay_src[2 * PL + i]) bad++;
            if (bad != 0) begin
                errors++; $display("FAIL loss_payload got %0d wrong bits exp 0", bad);
            end
        end
    endtask

    task automatic test_verify_fail();
        do_reset();
        build_stream(7, 32'h0000_0004, 0);
        for (int i = 0; i < tx.size(); i++) begin
            drive(1'b1, tx[i]);
            checks++;
            if (out_valid !== e_ov || frame_start !== e_fs || sync_state !== m_state[1:0] ||
                lock !== (m_state == 2) || out_data !== e_od) begin
                errors++;
                $display("FAIL vfy_cycle bit=%0d got v=%b fs=%b st=%0d d=%b exp v=%b fs=%b st=%0d d=%b",
                         i + 1, out_valid, frame_start, sync_state, out_data, e_ov, e_fs, m_state, e_od);
            end
            if (i + 1 == 2 * FL + SL) begin
                checks++;
                if (sync_state !== 2'd0) begin
                    errors++; $display("FAIL vfy_to_hunt got st=%0d exp 0", sync_state);
                end
            end
        end
        checks++;
        if (dut_lock_at != 4 * FL + SL) begin
            errors++; $display("FAIL vfy_lock_at got %0d exp %0d", dut_lock_at, 4 * FL + SL);
        end
        checks++;
        if (got_q.size() != 3 * PL || fs_cnt != 3) begin
            errors++; $display("FAIL vfy_count got bits=%0d fs=%0d exp %0d 3", got_q.size(), fs_cnt, 3 * PL);
        end else begin
            int bad = 0;
            for (int i = 0; i < 3 * PL; i++) if (got_q[i] !== pay_src[4 * PL + i]) bad++;
            if (bad != 0) begin
                errors++; $display("FAIL vfy_payload got %0d wrong bits exp 0", bad);
            end
        end
    endtask

    task automatic test_gapped();
        int idles;
        logic [1:0] st_before;
        do_reset();
        build_stream(6, 32'h0, 0);
        for (int i = 0; i < tx.size(); i++) begin
            idles = $urandom_range(0, 2);
            for (int k = 0; k < idles; k++) begin
                st_before = sync_state;
                drive(1'b0, 1'($urandom_range(0, 1)));
                checks++;
                if (out_valid !== 1'b0 || frame_start !== 1'b0 || sync_state !== st_before ||
                    sync_state !== m_state[1:0] || out_data !== e_od) begin
                    errors++;
                    $display("FAIL gap_idle bit=%0d got v=%b fs=%b st=%0d d=%b exp v=0 fs=0 st=%0d d=%b",
                             i, out_valid, frame_start, sync_state, out_data, m_state, e_od);
                end
            end
            drive(1'b1, tx[i]);
            checks++;
            if (out_valid !== e_ov || frame_start !== e_fs || sync_state !== m_state[1:0] ||
                lock !== (m_state == 2) || out_data !== e_od) begin
                errors++;
                $display("FAIL gap_cycle bit=%0d got v=%b fs=%b st=%0d d=%b exp v=%b fs=%b st=%0d d=%b",
                         i + 1, out_valid, frame_start, sync_state, out_data, e_ov, e_fs, m_state, e_od);
            end
        end
        checks++;
        if (got_q.size() != 4 * PL || fs_cnt != 4) begin
            errors++; $display("FAIL gap_count got bits=%0d fs=%0d exp %0d 4", got_q.size(), fs_cnt, 4 * PL);
        end else begin
            int bad = 0;
            for (int i = 0; i < 4 * PL; i++) if (got_q[i] !== pay_src[2 * PL + i]) bad++;
            if (bad != 0) begin
                errors++; $display("FAIL gap_payload got %0d wrong bits exp 0", bad);
            end
        end
    endtask

    task automatic test_async_reset();
        int stop_at;
        do_reset();
        build_stream(6, 32'h0, 0);
        stop_at = 3 * FL + SL + 100;
        for (int i = 0; i < stop_at; i++) begin
            drive(1'b1, tx[i]);
            checks++;
            if (out_valid !== e_ov || sync_state !== m_state[1:0] || out_data !== e_od) begin
                errors++;
                $display("FAIL ar_cycle bit=%0d got v=%b st=%0d d=%b exp v=%b st=%0d d=%b",
                         i + 1, out_valid, sync_state, out_data, e_ov, m_state, e_od);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (lock !== 1'b0 || out_valid !== 1'b0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL ar_clear got lock=%b v=%b fs=%b exp 0 0 0", lock, out_valid, frame_start);
        end
        checks++;
        if (sync_state !== 2'd0) begin
            errors++; $display("FAIL ar_state got %0d exp 0", sync_state);
        end
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < tx.size(); i++) begin
            drive(1'b1, tx[i]);
            checks++;
            if (out_valid !== e_ov || frame_start !== e_fs || sync_state !== m_state[1:0] ||
                lock !== (m_state == 2) || out_data !== e_od) begin
                errors++;
                $display("FAIL ar_relock_cycle bit=%0d got v=%b fs=%b st=%0d d=%b exp v=%b fs=%b st=%0d d=%b",
                         i + 1, out_valid, frame_start, sync_state, out_data, e_ov, e_fs, m_state, e_od);
            end
        end
        checks++;
        if (dut_lock_at != 2 * FL + SL) begin
            errors++; $display("FAIL ar_lock_at got %0d exp %0d", dut_lock_at, 2 * FL + SL);
        end
        checks++;
        if (got_q.size() != 4 * PL || fs_cnt != 4) begin
            errors++; $display("FAIL ar_count got bits=%0d fs=%0d exp %0d 4", got_q.size(), fs_cnt, 4 * PL);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_scramble_data = 1'b0;
        test_reset();
        test_acquire();
        test_misaligned();
        test_loss();
        test_verify_fail();
        test_gapped();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
